// File: rtl/merging_if.sv
// Handshake bundle for the pixel merger: serial word input side, assembled frame output side.
// The merging block connects through the slave modport; the producer/consumer uses master.
interface merging_if #(
  parameter int TOTALPIXEL = 9,
  parameter int DATA_W     = 32,
  parameter int CW         = $clog2(TOTALPIXEL + 1)
) ();
  logic [DATA_W-1:0]            in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [TOTALPIXEL*DATA_W-1:0] conv_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [CW-1:0]                count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, conv_in, out_valid, count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, conv_in, out_valid, count
  );
endinterface

// File: rtl/merging.sv
// Collects TOTALPIXEL serial words into one wide frame and hands it on with valid/ready.
// A frame being consumed can overlap the first word of the next one, so streaming has no bubble.
module merging #(
  parameter int TOTALPIXEL = 9,
  parameter int DATA_W     = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  merging_if.slave  bus
);
  localparam int CW = $clog2(TOTALPIXEL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTALPIXEL - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              out_valid_reg;
  logic              in_xfer, out_xfer;
  logic              wr_en;
  logic [CW-1:0]     wr_idx;
  logic [DATA_W-1:0] slot_reg [TOTALPIXEL];

  // Ready depends only on state and the consumer, never on in_valid.
  assign bus.in_ready  = (state_reg == FILL) | bus.out_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.count     = count_reg;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = out_valid_reg & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = count_reg;
    if (flush) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_xfer) begin
            wr_en = 1'b1;
            if (count_reg == LAST_IDX) begin
              count_next = '0;
              state_next = FULL;
            end else begin
              count_next = count_reg + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_xfer) begin
            if (in_xfer) begin
              // Word arriving as the frame leaves starts the next frame at slot 0.
              wr_en  = 1'b1;
              wr_idx = '0;
              if (TOTALPIXEL == 1) begin
                state_next = FULL;
                count_next = '0;
              end else begin
                state_next = FILL;
                count_next = CW'(1);
              end
            end else begin
              state_next = FILL;
              count_next = '0;
            end
          end
        end
        default: begin
          state_next = FILL;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= FILL;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      out_valid_reg <= (state_next == FULL);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < TOTALPIXEL; gi++) begin : g_slot
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == CW'(gi))) begin
          slot_reg[gi] <= bus.in_data;
        end
      end
      assign bus.conv_in[gi*DATA_W +: DATA_W] = slot_reg[gi];
    end
  endgenerate
endmodule

// File: tb/tb_merging.sv
// Drives identical traffic into a 9-word and a 1-word merger and checks both against
// a queue-style frame model: words accumulate until a frame is complete, then it is held.
module tb_merging;
  localparam int DW = 32;
  localparam int T0 = 9;
  localparam int T1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  merging_if #(.TOTALPIXEL(T0), .DATA_W(DW)) bus0 ();
  merging_if #(.TOTALPIXEL(T1), .DATA_W(DW)) bus1 ();

  merging #(.TOTALPIXEL(T0), .DATA_W(DW)) dut0 (.clk(clk), .reset(reset), .flush(flush), .bus(bus0));
  merging #(.TOTALPIXEL(T1), .DATA_W(DW)) dut1 (.clk(clk), .reset(reset), .flush(flush), .bus(bus1));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model, one entry per DUT (0: nine words, 1: one word).
  int          part_n  [2];
  logic [31:0] part    [2][16];
  logic        full    [2];
  logic [31:0] frame   [2][16];
  int          nframes [2];

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tp(input int m);
    return (m == 0) ? T0 : T1;
  endfunction

  function automatic logic [287:0] exp_frame(input int m);
    logic [287:0] e;
    e = '0;
    for (int k = 0; k < tp(m); k++) e[k*32 +: 32] = frame[m][k];
    return e;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      part_n[m] = 0;
      full[m]   = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic iv, input logic [31:0] d,
                            input logic ordy, input logic fl);
    logic rdy;
    if (fl) begin
      part_n[m] = 0;
      full[m]   = 1'b0;
    end else begin
      rdy = !full[m] || ordy;
      if (full[m] && ordy) full[m] = 1'b0;
      if (iv && rdy) begin
        part[m][part_n[m]] = d;
        part_n[m]++;
        if (part_n[m] == tp(m)) begin
          for (int k = 0; k < tp(m); k++) frame[m][k] = part[m][k];
          full[m]   = 1'b1;
          part_n[m] = 0;
          nframes[m]++;
          $display("dut%0d frame %0d assembled, last word %08h", m, nframes[m], d);
        end
      end
    end
  endtask

  task automatic check_outputs(input logic ordy);
    check("in_ready0", 288'(bus0.in_ready), 288'(!full[0] || ordy));
    check("out_valid0", 288'(bus0.out_valid), 288'(full[0]));
    check("count0", 288'(bus0.count), 288'(part_n[0]));
    if (full[0]) check("conv_in0", bus0.conv_in, exp_frame(0));
    check("in_ready1", 288'(bus1.in_ready), 288'(!full[1] || ordy));
    check("out_valid1", 288'(bus1.out_valid), 288'(full[1]));
    check("count1", 288'(bus1.count), 288'(part_n[1]));
    if (full[1]) check("conv_in1", 288'(bus1.conv_in), exp_frame(1));
  endtask

  // Called at a falling edge: drive, check the pre-edge view, then advance across the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bus0.in_valid = iv;  bus0.in_data = d;  bus0.out_ready = ordy;
    bus1.in_valid = iv;  bus1.in_data = d;  bus1.out_ready = ordy;
    flush = fl;
    #1;
    check_outputs(ordy);
    @(posedge clk);
    model_step(0, iv, d, ordy, fl);
    model_step(1, iv, d, ordy, fl);
    @(negedge clk);
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, "_ov0"},  288'(bus0.out_valid), 288'(0));
    check({tag, "_cnt0"}, 288'(bus0.count), 288'(0));
    check({tag, "_cv0"},  bus0.conv_in, 288'(0));
    check({tag, "_ir0"},  288'(bus0.in_ready), 288'(1));
    check({tag, "_ov1"},  288'(bus1.out_valid), 288'(0));
    check({tag, "_cv1"},  288'(bus1.conv_in), 288'(0));
    check({tag, "_ir1"},  288'(bus1.in_ready), 288'(1));
  endtask

  initial begin
    nframes[0] = 0;
    nframes[1] = 0;
    model_reset();
    reset = 1'b0;
    flush = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_view("rst");
    reset = 1'b1;

    // Nine consecutive words with the consumer always ready.
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("lo_word", 288'(bus0.conv_in[31:0]), 288'(32'h10));
    check("hi_word", 288'(bus0.conv_in[287:256]), 288'(32'h18));

    // Hold a complete frame under backpressure, then release with 0xAA waiting.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hAA, 1'b0, 1'b0);
    cycle(1'b1, 32'hAA, 1'b1, 1'b0);
    check("aa_count", 288'(bus0.count), 288'(1));
    check("aa_slot0", 288'(bus0.conv_in[31:0]), 288'(32'hAA));

    // Gapped valid across a whole frame.
    for (int i = 0; i < 18; i++) cycle(i[0] == 1'b0, 32'h30 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush after four words; 0x55 must not land anywhere.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h40 + 32'(i), 1'b1, 1'b0);
    cycle(1'b1, 32'h55, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a cycle while holding a full frame.
    #2 reset = 1'b0;
    #1 check_reset_view("areset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Single-word frames streaming back to back.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
    check("t1_last", 288'(bus1.conv_in), 288'(32'h3));

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
